// File: rtl/axis_burst_reader_if.sv
// AXI-Stream link used on both sides of the burst reader.
// tlevel carries the FIFO fill level on the FIFO side and is tied off on the output side.
interface axis_burst_reader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int USER_WIDTH  = 1,
    parameter int LEVEL_WIDTH = 3
);
    logic [DATA_WIDTH-1:0]  tdata;
    logic [USER_WIDTH-1:0]  tuser;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;
    logic [LEVEL_WIDTH-1:0] tlevel;

    modport master (output tdata, tuser, tlast, tvalid, tlevel, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, tlevel, output tready);
endinterface

// File: rtl/axis_burst_reader.sv
// Waits until a full burst is buffered in the upstream FIFO, then drains up to BURST_LEN
// beats and re-emits them as one framed packet; an input tlast closes a burst early.
module axis_burst_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int USER_WIDTH  = 1,
    parameter int LEVEL_WIDTH = 3,
    parameter int BURST_LEN   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    axis_burst_reader_if.slave         s_axis_in,
    axis_burst_reader_if.master        m_axis_out,
    output logic [15:0]                burst_cnt_o,
    output logic                       short_burst_o,
    output logic                       busy_o
);
    // state | meaning
    // IDLE  | not pulling; waiting for FIFO level >= BURST_LEN
    // READ  | pulling beats until BURST_LEN taken or input tlast seen
    typedef enum logic {IDLE, READ} state_t;

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MIN = LEVEL_WIDTH'(BURST_LEN);

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;
    logic                  short_q, short_d;
    logic                  busy_q, busy_d;
    logic                  in_ready;
    logic                  accept;
    logic                  fin;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        burst_cnt_d = burst_cnt_q;
        short_d     = 1'b0;
        fin         = 1'b0;

        // Pull only while the output register is free or draining this cycle.
        in_ready = (state_q == READ) && (!tvalid_q || m_axis_out.tready);
        accept   = in_ready && s_axis_in.tvalid;

        if (accept) begin
            tvalid_d = 1'b1;
        end else if (m_axis_out.tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_axis_in.tlevel >= LEVEL_MIN) begin
                    state_d    = READ;
                    beat_cnt_d = '0;
                end
            end
            READ: begin
                if (accept) begin
                    fin        = (beat_cnt_q == LAST_BEAT) || s_axis_in.tlast;
                    tdata_d    = s_axis_in.tdata;
                    tuser_d    = s_axis_in.tuser;
                    tlast_d    = fin;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (fin) begin
                        state_d     = IDLE;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        short_d     = (beat_cnt_q < LAST_BEAT);
                        beat_cnt_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == READ);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            burst_cnt_q <= '0;
            short_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            burst_cnt_q <= burst_cnt_d;
            short_q     <= short_d;
            busy_q      <= busy_d;
        end
    end

    assign s_axis_in.tready  = in_ready;
    assign m_axis_out.tdata  = tdata_q;
    assign m_axis_out.tuser  = tuser_q;
    assign m_axis_out.tlast  = tlast_q;
    assign m_axis_out.tvalid = tvalid_q;
    assign m_axis_out.tlevel = '0;
    assign burst_cnt_o       = burst_cnt_q;
    assign short_burst_o     = short_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_axis_burst_reader.sv
// Bench for axis_burst_reader: FIFO model on the input, scoreboard of framed beats on the output.
module tb_axis_burst_reader;
    localparam int DW = 16;
    localparam int UW = 1;
    localparam int LW = 3;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_burst_reader_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEVEL_WIDTH(LW)) s_if ();
    axis_burst_reader_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEVEL_WIDTH(LW)) m_if ();

    logic [15:0] burst_cnt;
    logic        short_burst;
    logic        busy;

    axis_burst_reader #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .LEVEL_WIDTH(LW), .BURST_LEN(BL)) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .s_axis_in    (s_if),
        .m_axis_out   (m_if),
        .burst_cnt_o  (burst_cnt),
        .short_burst_o(short_burst),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        int         nbeats;
        logic [7:0] last_mask;
        logic [3:0] rdy;
        int         exp_acc;
        int         exp_bursts;
        int         exp_shorts;
    } vec_t;

    beat_t       fifo_q[$];
    beat_t       sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = '0;
    bit          exp_short = 0;
    bit          in_burst = 0;
    int          burst_pos = 0;
    bit          rand_ready = 0;
    logic [3:0]  ready_pat = 4'b1111;
    int          cyc_idx = 0;
    int          accepts = 0;
    int          out_beats = 0;
    int          short_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit l);
        beat_t b;
        b.data = d;
        b.user = d[0];
        b.last = l;
        fifo_q.push_back(b);
    endtask

    // One clock: check registered outputs, drive inputs, advance the reference model.
    task automatic cycle();
        beat_t b;
        bit    acc;
        bit    fin;
        int    lvl;
        @(negedge clk);
        chk("m_tvalid", m_if.tvalid, sb_q.size() > 0);
        if (sb_q.size() > 0) begin
            chk("m_tdata", m_if.tdata, sb_q[0].data);
            chk("m_tuser", m_if.tuser, sb_q[0].user);
            chk("m_tlast", m_if.tlast, sb_q[0].last);
        end
        chk("burst_cnt", burst_cnt, exp_cnt);
        chk("short_burst", short_burst, exp_short);
        chk("busy", busy, in_burst);
        if (short_burst === 1'b1) short_pulses++;

        m_if.tready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_pat[cyc_idx % 4];
        cyc_idx++;
        lvl = (fifo_q.size() > 7) ? 7 : fifo_q.size();
        s_if.tlevel = LW'(lvl);
        if (fifo_q.size() > 0) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = fifo_q[0].data;
            s_if.tuser  = fifo_q[0].user;
            s_if.tlast  = fifo_q[0].last;
        end else begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = '0;
            s_if.tuser  = '0;
            s_if.tlast  = 1'b0;
        end
        #1;
        chk("s_tready", s_if.tready, in_burst && (sb_q.size() == 0 || m_if.tready));
        acc = s_if.tvalid && s_if.tready;

        exp_short = 0;
        if (sb_q.size() > 0 && m_if.tready) begin
            void'(sb_q.pop_front());
            out_beats++;
        end
        if (acc) begin
            b = fifo_q.pop_front();
            fin = b.last || (burst_pos == BL - 1);
            b.last = fin;
            sb_q.push_back(b);
            accepts++;
            if (fin) begin
                exp_cnt++;
                exp_short = (burst_pos < BL - 1);
                burst_pos = 0;
                in_burst  = 0;
            end else begin
                burst_pos++;
            end
        end else if (!in_burst && lvl >= BL) begin
            in_burst = 1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || sb_q.size() > 0 || in_burst) && n < 200) begin
            cycle();
            n++;
        end
        chk({name, "_drain_in_budget"}, n < 200, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          a0, o0, s0, n, busy_cycles, first_valid, valid_cnt;
        logic [15:0] c0;
        logic [DW-1:0] seen[$];
        logic          seen_last[$];

        vecs[0] = '{4, 8'h00, 4'b1111, 4, 1, 0};
        vecs[1] = '{4, 8'h00, 4'b1001, 4, 1, 0};
        vecs[2] = '{6, 8'h02, 4'b1111, 6, 2, 1};
        vecs[3] = '{8, 8'h00, 4'b1111, 8, 2, 0};
        vecs[4] = '{5, 8'h01, 4'b1011, 5, 2, 1};
        vecs[5] = '{4, 8'h08, 4'b1111, 4, 1, 0};
        vecs[6] = '{7, 8'h04, 4'b0110, 7, 2, 1};
        vecs[7] = '{4, 8'h00, 4'b0101, 4, 1, 0};

        s_if.tvalid = 0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 0; s_if.tlevel = '0;
        m_if.tready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_tuser", m_if.tuser, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_short", short_burst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_tready", s_if.tready, 0);
        rst_n = 1;

        // Reset two beats into a burst.
        for (int i = 0; i < 4; i++) push(16'hD0 + 16'(i), 0);
        a0 = accepts;
        n = 0;
        while (accepts - a0 < 2 && n < 20) begin cycle(); n++; end
        chk("rst_mid_two_accepts", accepts - a0, 2);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_tvalid", m_if.tvalid, 0);
        chk("rst_mid_tdata", m_if.tdata, 0);
        chk("rst_mid_tlast", m_if.tlast, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_s_tready", s_if.tready, 0);
        chk("rst_mid_burst_cnt", burst_cnt, 0);
        sb_q.delete(); fifo_q.delete();
        in_burst = 0; burst_pos = 0; exp_cnt = '0; exp_short = 0;
        repeat (2) cycle();
        rst_n = 1;

        // Fresh burst A0..A3 with downstream always ready.
        for (int i = 0; i < 4; i++) push(16'hA0 + 16'(i), 0);
        busy_cycles = 0; first_valid = -1; valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (busy === 1'b1) busy_cycles++;
            if (m_if.tvalid === 1'b1) begin
                if (first_valid < 0) first_valid = i;
                valid_cnt++;
                seen.push_back(m_if.tdata);
                seen_last.push_back(m_if.tlast);
            end
        end
        chk("t1_busy_cycles", busy_cycles, 4);
        chk("t1_valid_cycles", valid_cnt, 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk("t1_data", seen[i], 16'hA0 + 16'(i));
            chk("t1_last", seen_last[i], i == 3);
        end
        chk("t1_burst_cnt", burst_cnt, 1);

        // Level 3 is not enough; the fourth beat starts a burst.
        for (int i = 0; i < 3; i++) push(16'hC0 + 16'(i), 0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("lvl3_s_tready", s_if.tready, 0);
            chk("lvl3_m_tvalid", m_if.tvalid, 0);
        end
        push(16'hC3, 0);
        cycle();
        cycle();
        chk("lvl4_busy", busy, 1);
        drain("lvl4");

        // Table-driven bursts.
        for (int r = 0; r < 8; r++) begin
            a0 = accepts; o0 = out_beats; s0 = short_pulses; c0 = burst_cnt;
            ready_pat = vecs[r].rdy;
            cyc_idx = 0;
            for (int i = 0; i < vecs[r].nbeats; i++)
                push(16'h100 * 16'(r + 1) + 16'(i), vecs[r].last_mask[i]);
            drain("vec");
            cycle();
            chk("vec_accepts", accepts - a0, vecs[r].exp_acc);
            chk("vec_out_beats", out_beats - o0, vecs[r].exp_acc);
            chk("vec_bursts", 32'(burst_cnt - c0), vecs[r].exp_bursts);
            chk("vec_shorts", short_pulses - s0, vecs[r].exp_shorts);
        end
        ready_pat = 4'b1111;

        // Burst counter wrap.
        force dut.burst_cnt_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        cycle();
        release dut.burst_cnt_q;
        for (int i = 0; i < 4; i++) push(16'hE0 + 16'(i), 0);
        drain("wrap");
        chk("wrap_burst_cnt", burst_cnt, 16'h0000);

        // Random traffic with random downstream backpressure.
        rand_ready = 1;
        for (int i = 0; i < 4000; i++) begin
            if (fifo_q.size() < 8 && $urandom_range(0, 1) == 1)
                push(DW'($urandom_range(0, 65535)), $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_burst_reader.md
# axis_burst_reader

Read-side companion to the team's AXIS FIFO: attaches to the FIFO's output stream, waits until a full burst is buffered, then drains exactly BURST_LEN beats and re-emits them as one framed AXI-Stream packet with tlast on the final beat. Used in front of FFT/demod blocks that need gap-free bursts of samples. Single clock domain; downstream backpressure is honoured.

## Interface
- DATA_WIDTH, 16, tdata width
- USER_WIDTH, 1, tuser width (≥1)
- LEVEL_WIDTH, 3, width of FIFO level input (= clog2 of FIFO_LEN)
- BURST_LEN, 4, beats per burst; 1 ≤ BURST_LEN < 2^LEVEL_WIDTH
- clk_i  in  1  clock
- reset_ni  in  1  reset; one clock; asynchronous, active-low
- s_axis_in_tdata  in  DATA_WIDTH  data from FIFO
- s_axis_in_tuser  in  USER_WIDTH  user from FIFO
- s_axis_in_tlast  in  1  tlast from FIFO
- s_axis_in_tvalid  in  1  FIFO output valid
- s_axis_in_tready  out  1  pull strobe to FIFO (combinational)
- s_axis_in_tlevel  in  LEVEL_WIDTH  FIFO fill level incl. its output register
- m_axis_out_tdata  out  DATA_WIDTH  registered output data
- m_axis_out_tuser  out  USER_WIDTH  registered output user
- m_axis_out_tlast  out  1  last beat of burst
- m_axis_out_tvalid  out  1  output valid
- m_axis_out_tready  in  1  downstream ready
- burst_cnt_o  out  16  completed bursts, wraps at 2^16
- short_burst_o  out  1  one-cycle pulse: burst ended early by input tlast
- busy_o  out  1  high in state READ

## Operation
- States: IDLE, READ. Reset → IDLE.
- IDLE: s_axis_in_tready = 0. If s_axis_in_tlevel ≥ BURST_LEN (unsigned compare) → READ next cycle; beat_cnt ← 0.
- READ: s_axis_in_tready = (!m_axis_out_tvalid || m_axis_out_tready). Accept = s_axis_in_tvalid && s_axis_in_tready.
- On accept: output regs ← input tdata/tuser; m_axis_out_tlast ← (beat_cnt == BURST_LEN−1) || s_axis_in_tlast; beat_cnt +1 (width clog2(BURST_LEN+1)).
- Accept with computed tlast = 1 → IDLE next cycle; burst_cnt_o +1; if beat_cnt < BURST_LEN−1 (input tlast early) pulse short_burst_o, beat_cnt cleared.
- m_axis_out_tvalid: set on accept; cleared when m_axis_out_tready && !accept; held otherwise (AXIS: data/user/last stable while valid && !ready).
- FIFO empty bubbles in READ (tvalid low) stall counting; no timeout; burst completes only on BURST_LEN beats or input tlast.
- Never accepts more than BURST_LEN beats per burst; never accepts in IDLE.

## Timing
- Reset (async assert, sync-released use): m_axis_out_tdata/tuser/tlast/tvalid = 0, burst_cnt_o = 0, short_burst_o = 0, busy_o = 0, s_axis_in_tready = 0, beat_cnt = 0.
- Level condition seen in cycle n → busy_o and s_axis_in_tready can be high in n+1.
- Input-to-output latency: 1 cycle (accept in n → m_axis_out_tvalid in n+1).
- Full throughput: with m_axis_out_tready = 1 and FIFO valid, one beat per cycle; burst of B beats occupies B cycles in READ.
- Gap between bursts: ≥1 IDLE cycle (level re-evaluated in IDLE).
- Simultaneous final accept and downstream ready on previous beat: both occur; tvalid stays 1.
- Reset mid-burst: burst aborted, no burst_cnt_o increment, partial output discarded.
- burst_cnt_o 0xFFFF +1 → 0x0000.

## Test plan
- BURST_LEN=4, preload 4 beats 0xA0..0xA3, tready=1 → outputs A0..A3 on 4 consecutive cycles, tlast only with A3, burst_cnt_o=1, busy_o 4 cycles.
- Level 3 < 4 held 20 cycles → s_axis_in_tready stays 0, no output; 4th beat arrives → burst starts next cycle.
- Downstream tready toggling 1,0,0,1… during burst → each beat held stable while stalled, no loss/duplication, exactly 4 accepts.
- Input tlast on 2nd beat (0xB0,0xB1) → output tlast on B1, short_burst_o pulses once, burst_cnt_o +1, state IDLE.
- 8 beats buffered → two bursts with ≥1 IDLE cycle between, burst_cnt_o=2; burst_cnt_o forced to 0xFFFF then a burst → 0x0000.
- reset_ni low after 2 beats of a burst → all outputs 0 immediately, burst_cnt_o unchanged at 0, fresh burst after release behaves normally.
